// File: rtl/pong_match_ctrl.sv
// Ping-pong match controller: ball track stepping, returns, fouls, misses,
// point flash, loser-serves rule and match-over display.
module pong_match_ctrl #(
    parameter int unsigned N_LED         = 8,
    parameter int unsigned TICK_DIV_INIT = 25_000_000,
    parameter int unsigned TICK_DIV_MIN  = 5_000_000,
    parameter int unsigned SPEEDUP_SHIFT = 3,
    parameter int unsigned WIN_SCORE     = 11,
    parameter int unsigned SCORE_W       = 4,
    parameter int unsigned POINT_HOLD    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_p1_eff,
    input  logic               key_p2_eff,
    output logic [N_LED-1:0]   position,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               serve_p2,
    output logic               game_over,
    output logic               winner_p2,
    output logic [7:0]         rally_len
);

    localparam int unsigned DIV_W  = $clog2(TICK_DIV_INIT + 1);
    localparam int unsigned HOLD_W = $clog2(POINT_HOLD + 1);

    localparam logic [DIV_W-1:0]   DIV_INIT = DIV_W'(TICK_DIV_INIT);
    localparam logic [DIV_W-1:0]   DIV_MIN  = DIV_W'(TICK_DIV_MIN);
    localparam logic [HOLD_W-1:0]  HOLD_END = HOLD_W'(POINT_HOLD - 1);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
    localparam logic [N_LED-1:0]   P1_END   = N_LED'(1);
    localparam logic [N_LED-1:0]   P2_END   = {1'b1, {(N_LED-1){1'b0}}};
    localparam logic [N_LED-1:0]   ALL_ON   = {N_LED{1'b1}};
    // Lower ceil(N/2) bits form player 1's half of the track.
    localparam logic [N_LED-1:0]   HALF_P1  = ALL_ON >> (N_LED / 2);

    typedef enum logic [2:0] {
        S_SERVE,
        S_MOVE_UP,
        S_MOVE_DN,
        S_POINT,
        S_OVER
    } state_t;

    state_t             state_q, state_d;
    logic [N_LED-1:0]   pos_q, pos_d;
    logic [SCORE_W-1:0] score_p1_q, score_p1_d;
    logic [SCORE_W-1:0] score_p2_q, score_p2_d;
    logic               serve_p2_q, serve_p2_d;
    logic               game_over_q, game_over_d;
    logic               winner_p2_q, winner_p2_d;
    logic               scorer_p2_q, scorer_p2_d;
    logic [7:0]         rally_q, rally_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [HOLD_W-1:0]  flash_q, flash_d;

    logic               step;
    logic [DIV_W-1:0]   div_sped;
    logic [DIV_W-1:0]   div_fast;
    logic               award;
    logic               award_p2;
    logic [SCORE_W-1:0] scorer_score;

    // Next-state: keys beat the step pulse; award handled after the case.
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        score_p1_d   = score_p1_q;
        score_p2_d   = score_p2_q;
        serve_p2_d   = serve_p2_q;
        game_over_d  = game_over_q;
        winner_p2_d  = winner_p2_q;
        scorer_p2_d  = scorer_p2_q;
        rally_d      = rally_q;
        div_d        = div_q;
        cnt_d        = cnt_q;
        flash_d      = flash_q;
        award        = 1'b0;
        award_p2     = 1'b0;

        step         = (cnt_q == div_q - DIV_W'(1));
        div_sped     = div_q - (div_q >> SPEEDUP_SHIFT);
        div_fast     = (div_sped < DIV_MIN) ? DIV_MIN : div_sped;
        scorer_score = scorer_p2_q ? score_p2_q : score_p1_q;

        case (state_q)
            S_SERVE: begin
                if (serve_p2_q ? key_p2_eff : key_p1_eff) begin
                    state_d = serve_p2_q ? S_MOVE_DN : S_MOVE_UP;
                    div_d   = DIV_INIT;
                    rally_d = 8'd0;
                    cnt_d   = '0;
                end
            end
            S_MOVE_UP: begin
                if (key_p2_eff) begin
                    if (pos_q[N_LED-1]) begin
                        state_d = S_MOVE_DN;
                        rally_d = (rally_q == 8'hFF) ? rally_q : rally_q + 8'd1;
                        div_d   = div_fast;
                        cnt_d   = '0;
                    end else begin
                        award = 1'b1;
                    end
                end else if (step) begin
                    if (pos_q[N_LED-1]) begin
                        award = 1'b1;
                    end else begin
                        pos_d = pos_q << 1;
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_MOVE_DN: begin
                if (key_p1_eff) begin
                    if (pos_q[0]) begin
                        state_d = S_MOVE_UP;
                        rally_d = (rally_q == 8'hFF) ? rally_q : rally_q + 8'd1;
                        div_d   = div_fast;
                        cnt_d   = '0;
                    end else begin
                        award    = 1'b1;
                        award_p2 = 1'b1;
                    end
                end else if (step) begin
                    if (pos_q[0]) begin
                        award    = 1'b1;
                        award_p2 = 1'b1;
                    end else begin
                        pos_d = pos_q >> 1;
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_POINT: begin
                if (step) begin
                    cnt_d = '0;
                    if (flash_q == HOLD_END) begin
                        if (scorer_score == WIN) begin
                            state_d     = S_OVER;
                            game_over_d = 1'b1;
                            winner_p2_d = scorer_p2_q;
                            pos_d       = scorer_p2_q ? ~HALF_P1 : HALF_P1;
                        end else begin
                            state_d    = S_SERVE;
                            serve_p2_d = ~scorer_p2_q;
                            pos_d      = scorer_p2_q ? P1_END : P2_END;
                        end
                    end else begin
                        pos_d   = ~pos_q;
                        flash_d = flash_q + HOLD_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_OVER: begin
                if (key_p1_eff || key_p2_eff) begin
                    state_d     = S_SERVE;
                    score_p1_d  = '0;
                    score_p2_d  = '0;
                    game_over_d = 1'b0;
                    serve_p2_d  = 1'b0;
                    pos_d       = P1_END;
                end
            end
            default: state_d = S_SERVE;
        endcase

        // Point entry: bump the scorer without wrapping and start the flash.
        if (award) begin
            state_d     = S_POINT;
            pos_d       = ALL_ON;
            cnt_d       = '0;
            div_d       = DIV_INIT;
            flash_d     = '0;
            scorer_p2_d = award_p2;
            if (award_p2) begin
                score_p2_d = (score_p2_q == WIN) ? score_p2_q : score_p2_q + SCORE_W'(1);
            end else begin
                score_p1_d = (score_p1_q == WIN) ? score_p1_q : score_p1_q + SCORE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_SERVE;
            pos_q       <= P1_END;
            score_p1_q  <= '0;
            score_p2_q  <= '0;
            serve_p2_q  <= 1'b0;
            game_over_q <= 1'b0;
            winner_p2_q <= 1'b0;
            scorer_p2_q <= 1'b0;
            rally_q     <= 8'd0;
            div_q       <= DIV_INIT;
            cnt_q       <= '0;
            flash_q     <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            score_p1_q  <= score_p1_d;
            score_p2_q  <= score_p2_d;
            serve_p2_q  <= serve_p2_d;
            game_over_q <= game_over_d;
            winner_p2_q <= winner_p2_d;
            scorer_p2_q <= scorer_p2_d;
            rally_q     <= rally_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            flash_q     <= flash_d;
        end
    end

    assign position  = pos_q;
    assign score_p1  = score_p1_q;
    assign score_p2  = score_p2_q;
    assign serve_p2  = serve_p2_q;
    assign game_over = game_over_q;
    assign winner_p2 = winner_p2_q;
    assign rally_len = rally_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed rally/foul/miss/game-over sequence,
// then randomized play checked each cycle against a ball-index/time model.
module tb_pong_match_ctrl;

    localparam int N     = 4;
    localparam int INIT  = 8;
    localparam int DMIN  = 2;
    localparam int SHIFT = 1;
    localparam int WIN   = 2;
    localparam int HOLD  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_p1 = 1'b0;
    logic       key_p2 = 1'b0;
    logic [3:0] position;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       serve_p2;
    logic       game_over;
    logic       winner_p2;
    logic [7:0] rally_len;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    pong_match_ctrl #(
        .N_LED(N), .TICK_DIV_INIT(INIT), .TICK_DIV_MIN(DMIN),
        .SPEEDUP_SHIFT(SHIFT), .WIN_SCORE(WIN), .SCORE_W(4), .POINT_HOLD(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .key_p1_eff(key_p1), .key_p2_eff(key_p2),
        .position(position), .score_p1(score_p1), .score_p2(score_p2),
        .serve_p2(serve_p2), .game_over(game_over), .winner_p2(winner_p2),
        .rally_len(rally_len)
    );

    always #5 clk = ~clk;

    // Game model: phase 0 serve, 1 ball in flight, 2 point flash, 3 match over.
    int ph, b, period, elapsed, flash_steps, sc1, sc2, rally;
    bit up, flash_on, m_serve_p2, m_winner, m_scorer;

    task automatic award(input bit to_p2);
        if (to_p2) sc2 = (sc2 < WIN) ? sc2 + 1 : sc2;
        else       sc1 = (sc1 < WIN) ? sc1 + 1 : sc1;
        m_scorer    = to_p2;
        ph          = 2;
        flash_on    = 1'b1;
        flash_steps = 0;
        elapsed     = 0;
        period      = INIT;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = 0; b = 0; up = 1'b1; period = INIT; elapsed = 0;
            flash_steps = 0; flash_on = 1'b0; sc1 = 0; sc2 = 0; rally = 0;
            m_serve_p2 = 1'b0; m_winner = 1'b0; m_scorer = 1'b0;
        end else begin
            case (ph)
                0: if (m_serve_p2 ? key_p2 : key_p1) begin
                    ph = 1; up = !m_serve_p2; b = m_serve_p2 ? N - 1 : 0;
                    period = INIT; elapsed = 0; rally = 0;
                end
                1: begin
                    bit recv_key, at_end;
                    recv_key = up ? key_p2 : key_p1;
                    at_end   = up ? (b == N - 1) : (b == 0);
                    if (recv_key) begin
                        if (at_end) begin
                            up = !up;
                            rally = (rally < 255) ? rally + 1 : 255;
                            period = period - period / (2 ** SHIFT);
                            if (period < DMIN) period = DMIN;
                            elapsed = 0;
                        end else award(!up);
                    end else if (elapsed + 1 == period) begin
                        if (at_end) award(!up);
                        else begin
                            b = up ? b + 1 : b - 1;
                            elapsed = 0;
                        end
                    end else elapsed++;
                end
                2: begin
                    if (elapsed + 1 == period) begin
                        elapsed = 0;
                        flash_steps++;
                        if (flash_steps == HOLD) begin
                            if ((m_scorer ? sc2 : sc1) == WIN) begin
                                ph = 3; m_winner = m_scorer;
                            end else begin
                                ph = 0; m_serve_p2 = !m_scorer;
                            end
                        end else flash_on = !flash_on;
                    end else elapsed++;
                end
                default: if (key_p1 || key_p2) begin
                    ph = 0; sc1 = 0; sc2 = 0; m_serve_p2 = 1'b0;
                end
            endcase
        end
    end

    function automatic logic [3:0] exp_pos();
        case (ph)
            0:       return m_serve_p2 ? 4'b1000 : 4'b0001;
            1:       return 4'(1 << b);
            2:       return flash_on ? 4'b1111 : 4'b0000;
            default: return m_winner ? 4'b1100 : 4'b0011;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("position", int'(position), int'(exp_pos()));
            check("score_p1", int'(score_p1), sc1);
            check("score_p2", int'(score_p2), sc2);
            check("serve_p2", int'(serve_p2), int'(m_serve_p2));
            check("game_over", int'(game_over), int'(ph == 3));
            check("rally_len", int'(rally_len), rally);
            if (ph == 3) check("winner_p2", int'(winner_p2), int'(m_winner));
        end
    end

    task automatic cyc(input bit a, input bit c);
        key_p1 = a;
        key_p2 = c;
        @(posedge clk);
        #2;
        key_p1 = 1'b0;
        key_p2 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bit k1, k2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_position", int'(position), 1);
        check("rst_scores", int'(score_p1) + int'(score_p2), 0);
        check("rst_game_over", int'(game_over), 0);

        // Serve, climb at 8-clk spacing, return, faster descent, early hit by p1.
        cyc(1, 0);
        repeat (8) cyc(0, 0);
        check("lit_step1", int'(position), 4'b0010);
        repeat (16) cyc(0, 0);
        check("lit_top", int'(position), 4'b1000);
        cyc(0, 1);
        check("lit_rally1", int'(rally_len), 1);
        repeat (4) cyc(0, 0);
        check("lit_fast_step", int'(position), 4'b0100);
        cyc(1, 0);
        check("lit_foul_flash", int'(position), 4'b1111);
        check("lit_foul_score", int'(score_p2), 1);
        repeat (16) cyc(0, 0);
        check("lit_p1_serves", int'(position), 4'b0001);
        check("lit_p1_serve_flag", int'(serve_p2), 0);

        // Unreturned ball: point to p1, then p2 serves.
        cyc(1, 0);
        repeat (48) cyc(0, 0);
        check("lit_miss_score", int'(score_p1), 1);
        check("lit_p2_serves", int'(position), 4'b1000);

        // Return on the exact expiry cycle, then both keys with p2 receiving.
        cyc(0, 1);
        repeat (31) cyc(0, 0);
        cyc(1, 0);
        check("lit_expiry_return", int'(rally_len), 1);
        check("lit_expiry_no_point", int'(score_p2), 1);
        repeat (4) cyc(0, 0);
        check("lit_after_expiry", int'(position), 4'b0010);
        cyc(1, 1);
        check("lit_both_keys", int'(score_p1), 2);
        repeat (16) cyc(0, 0);
        check("lit_game_over", int'(game_over), 1);
        check("lit_winner", int'(winner_p2), 0);
        check("lit_half", int'(position), 4'b0011);
        cyc(0, 1);
        check("lit_restart_pos", int'(position), 4'b0001);
        check("lit_restart_score", int'(score_p1), 0);

        // Randomized play with occasional reset during the point flash.
        for (int i = 0; i < 6000; i++) begin
            k1 = ($urandom % 50) == 0;
            k2 = ($urandom % 50) == 0;
            if (ph == 0 && ($urandom % 8) == 0) begin
                if (m_serve_p2) k2 = 1'b1; else k1 = 1'b1;
            end
            if (ph == 1 && ($urandom % 4) == 0) begin
                if (up && b == N - 1) k2 = 1'b1;
                if (!up && b == 0) k1 = 1'b1;
            end
            if (ph == 3 && ($urandom % 6) == 0) k1 = 1'b1;
            if (ph == 2 && ($urandom % 60) == 0) begin
                rst = 1'b1;
                #1;
                check("midflash_rst_pos", int'(position), 1);
                check("midflash_rst_score", int'(score_p1) + int'(score_p2), 0);
                check("midflash_rst_rally", int'(rally_len), 0);
                @(posedge clk);
                #2;
                rst = 1'b0;
            end else begin
                cyc(k1, k2);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
